// File: rtl/shift_rows_stream_if.sv
// shift_rows_stream_if: valid/ready bundle around the ShiftRows stage.
// The stage takes the slave view. The upstream/downstream side takes the master view.
// Optional feature macro: SHIFT_ROWS_INV_EN adds the per-block in_inv mode select.
interface shift_rows_stream_if #(
    parameter int LENGTH = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] in_data;
`ifdef SHIFT_ROWS_INV_EN
    logic              in_inv;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out_data;

`ifdef SHIFT_ROWS_INV_EN
    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: streaming Rijndael ShiftRows (Nb = 4/6/8) with a valid/ready
// handshake, a 2-entry skid buffer and a wrapping block counter.
// Optional feature macro: SHIFT_ROWS_INV_EN -- adds in_inv, selecting InvShiftRows per block.
// The shift is applied before a block enters a buffer, so each entry already holds data
// permuted by its own mode. No separate mode bit has to travel alongside it.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int BYTE  = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_rows_stream_if.slave bus,
    output logic [CNT_W-1:0]   blk_cnt
);
    localparam int LENGTH = 4 * NB * BYTE;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8, got %0d", NB);
    end

    // Encoded as {out_valid, skid_valid}. 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [LENGTH-1:0] out_data_q, out_data_d;
    logic [LENGTH-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

    logic              in_mode;
    logic              in_ready;
    logic              out_valid;
    logic              accept;
    logic              out_fire;
    logic [LENGTH-1:0] shifted;

    // Row r rotates left by sh(r) going forward and right going inverse.
    // Byte n = 4c+r sits MSB-first in the state vector.
    function automatic logic [LENGTH-1:0] shift_rows(input logic [LENGTH-1:0] s,
                                                     input logic inv);
        logic [LENGTH-1:0] r;
        int sh;
        int src_f;
        int src_i;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            sh = (NB == 8 && row >= 2) ? row + 1 : row;
            for (int col = 0; col < NB; col++) begin
                src_f = (col + sh) % NB;
                src_i = (col + NB - sh) % NB;
                r[LENGTH-1-BYTE*(4*col+row) -: BYTE] = inv
                    ? s[LENGTH-1-BYTE*(4*src_i+row) -: BYTE]
                    : s[LENGTH-1-BYTE*(4*src_f+row) -: BYTE];
            end
        end
        return r;
    endfunction

`ifdef SHIFT_ROWS_INV_EN
    assign in_mode = bus.in_inv;
`else
    assign in_mode = 1'b0;
`endif

    // in_ready is derived from the state register only, so out_ready never reaches it.
    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign accept    = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;
    assign shifted   = shift_rows(bus.in_data, in_mode);

    // Next-state, buffer steering and block counter.
    always_comb begin
        // NOTE: every *_d takes its hold value first, so no branch leaves one unassigned (no latch).
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        blk_cnt_d   = blk_cnt_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_data_d = shifted;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && bus.out_ready) begin
                    out_data_d = shifted;
                end else if (accept) begin
                    skid_data_d = shifted;
                    state_d     = ST_FULL;
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    out_data_d = skid_data_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (out_fire) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end
    end

    // State, buffers and counter registers. Reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well, because out_data must read zero after reset.
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            blk_cnt_q   <= '0;
        end else begin
            // NOTE: all state uses non-blocking assignments, so each flop samples pre-edge values.
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_q;
    assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: drives NB = 4, 6 and 8 instances in lockstep with shared handshake
// inputs. Every output block is compared against a byte/row-rotation reference model held
// in a scoreboard queue. Buffer occupancy predicts out_valid, in_ready and blk_cnt.
module tb_shift_rows_stream;

`ifdef SHIFT_ROWS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         inv_drv   = 1'b0;
    logic [255:0] din       = '0;

    logic [3:0]  cnt4;
    logic [15:0] cnt6;
    logic [15:0] cnt8;

    shift_rows_stream_if #(.LENGTH(128)) bus4 ();
    shift_rows_stream_if #(.LENGTH(192)) bus6 ();
    shift_rows_stream_if #(.LENGTH(256)) bus8 ();

    assign bus4.in_valid  = in_valid;
    assign bus6.in_valid  = in_valid;
    assign bus8.in_valid  = in_valid;
    assign bus4.out_ready = out_ready;
    assign bus6.out_ready = out_ready;
    assign bus8.out_ready = out_ready;
    assign bus4.in_data   = din[127:0];
    assign bus6.in_data   = din[191:0];
    assign bus8.in_data   = din;
`ifdef SHIFT_ROWS_INV_EN
    assign bus4.in_inv = inv_drv;
    assign bus6.in_inv = inv_drv;
    assign bus8.in_inv = inv_drv;
`endif

    shift_rows_stream #(.NB(4), .BYTE(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .blk_cnt(cnt4));
    shift_rows_stream #(.NB(6), .BYTE(8), .CNT_W(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6.slave), .blk_cnt(cnt6));
    shift_rows_stream #(.NB(8), .BYTE(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave), .blk_cnt(cnt8));

    typedef struct {
        logic [127:0] e4;
        logic [191:0] e6;
        logic [255:0] e8;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_hs     = 0;
    bit   last_acc;
    bit   last_hs;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: unpack to a 4 x nb byte grid, rotate each row as a queue, repack.
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input bit inv);
        byte unsigned st[4][8];
        byte unsigned row_q[$];
        int           sh8[4] = '{0, 1, 3, 4};
        int           len;
        int           sh;
        logic [255:0] r;
        len = 32 * nb;
        r   = '0;
        for (int n = 0; n < 4 * nb; n++) st[n % 4][n / 4] = d[len-1-8*n -: 8];
        for (int row = 0; row < 4; row++) begin
            sh = (nb == 8) ? sh8[row] : row;
            row_q.delete();
            for (int c = 0; c < nb; c++) row_q.push_back(st[row][c]);
            repeat (sh) begin
                if (inv) row_q.push_front(row_q.pop_back());
                else     row_q.push_back(row_q.pop_front());
            end
            for (int c = 0; c < nb; c++) st[row][c] = row_q[c];
        end
        for (int n = 0; n < 4 * nb; n++) r[len-1-8*n -: 8] = st[n % 4][n / 4];
        return r;
    endfunction

    task automatic rand_block();
        din     = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
        inv_drv = 1'($urandom_range(0, 1));
    endtask

    // One clock: score the handshakes that happen at this edge, advance, check control outputs.
    task automatic cycle();
        exp_t         e;
        exp_t         got_e;
        logic [255:0] t;
        bit           mode;
        last_acc = in_valid && bus4.in_ready;
        last_hs  = bus4.out_valid && out_ready;
        mode     = INV_EN ? inv_drv : 1'b0;
        if (last_hs) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 256'd1, 256'd0);
            end else begin
                got_e = sb.pop_front();
                check("out4", bus4.out_data, got_e.e4);
                check("out6", bus6.out_data, got_e.e6);
                check("out8", bus8.out_data, got_e.e8);
            end
            n_hs++;
        end
        if (last_acc) begin
            t = ref_shift(4, din, mode); e.e4 = t[127:0];
            t = ref_shift(6, din, mode); e.e6 = t[191:0];
            t = ref_shift(8, din, mode); e.e8 = t;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("valid4", bus4.out_valid, sb.size() != 0);
        check("valid6", bus6.out_valid, sb.size() != 0);
        check("valid8", bus8.out_valid, sb.size() != 0);
        check("ready4", bus4.in_ready, sb.size() < 2);
        check("ready6", bus6.in_ready, sb.size() < 2);
        check("ready8", bus8.in_ready, sb.size() < 2);
        check("cnt4", cnt4, n_hs % 16);
        check("cnt6", cnt6, n_hs % 65536);
        check("cnt8", cnt8, n_hs % 65536);
    endtask

    // Asynchronous assert mid-cycle; release lands between edges and is sampled on clk.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid4", bus4.out_valid, 1'b0);
        check("rst_valid8", bus8.out_valid, 1'b0);
        check("rst_ready4", bus4.in_ready, 1'b1);
        check("rst_ready8", bus8.in_ready, 1'b1);
        check("rst_data4", bus4.out_data, '0);
        check("rst_cnt4", cnt4, '0);
        sb.delete();
        n_hs = 0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_data6", bus6.out_data, '0);
        check("rel_cnt8", cnt8, '0);
    endtask

    initial begin
        int sent;
        int cyc;
        int first_hs;
        int last_hs_cyc;
        int hs_seen;

        do_reset();

        // FIPS-197 forward vector, visible one clock after accept.
        in_valid = 1'b1; out_ready = 1'b1; inv_drv = 1'b0;
        din = {128'h0, 128'hd42711aee0bf98f1b8b45de51e415230};
        cycle();
        check("fips_fwd", bus4.out_data, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        in_valid = 1'b0;
        cycle();

        // NB = 8 forward, byte n = n.
        in_valid = 1'b1; inv_drv = 1'b0;
        din = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        cycle();
        check("nb8_byte1",  bus8.out_data[247:240], 8'h05);
        check("nb8_byte2",  bus8.out_data[239:232], 8'h0E);
        check("nb8_byte3",  bus8.out_data[231:224], 8'h13);
        check("nb8_byte31", bus8.out_data[7:0],     8'h0F);
        in_valid = 1'b0;
        cycle();

`ifdef SHIFT_ROWS_INV_EN
        // Inverse vector, then per-block alternating mode at full rate.
        in_valid = 1'b1; inv_drv = 1'b1;
        din = {128'h0, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        cycle();
        check("fips_inv", bus4.out_data, 128'hd42711aee0bf98f1b8b45de51e415230);
        for (int i = 0; i < 8; i++) begin
            rand_block();
            inv_drv = 1'(i % 2);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
`endif

        // Backpressure: 5 blocks, out_ready low from the second cycle.
        do_reset();
        sent = 0;
        in_valid = 1'b1; out_ready = 1'b1; rand_block();
        cycle();
        if (last_acc) sent++;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            if (last_acc) rand_block();
            cycle();
            if (last_acc) sent++;
        end
        check("bp_ready_low", bus4.in_ready, 1'b0);
        check("bp_accepts", sent, 2);
        out_ready = 1'b1;
        cyc = 0; hs_seen = 0; first_hs = -1; last_hs_cyc = -1;
        while (hs_seen < 5 && cyc < 30) begin
            if (sent < 5) begin
                in_valid = 1'b1;
                if (last_acc) rand_block();
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (last_acc) sent++;
            if (last_hs) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs_cyc = cyc;
                hs_seen++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_exits", hs_seen, 5);
        check("bp_no_gap", last_hs_cyc - first_hs, 4);
        check("bp_cnt4", cnt4, 4'd5);
        check("bp_cnt8", cnt8, 16'd5);

        // Counter wrap on the 4-bit instance: 15 -> 0 -> 1 over handshakes 15..17.
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (n_hs < 17 && cyc < 40) begin
            rand_block();
            cycle();
            if (last_hs && n_hs == 15) check("wrap_15", cnt4, 4'd15);
            if (last_hs && n_hs == 16) check("wrap_0",  cnt4, 4'd0);
            if (last_hs && n_hs == 17) check("wrap_1",  cnt4, 4'd1);
            cyc++;
        end
        check("wrap_reached", n_hs, 17);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            rand_block();
            cycle();
        end

        // Fill to FULL, then reset mid-cycle.
        in_valid = 1'b1; out_ready = 1'b0;
        cyc = 0;
        while (bus4.in_ready && cyc < 4) begin
            rand_block();
            cycle();
            cyc++;
        end
        check("pre_rst_full", {bus4.out_valid, bus4.in_ready}, 2'b10);
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; rand_block();
        cycle();
        in_valid = 1'b0;
        cycle();
        check("post_rst_first", n_hs, 1);

        // Drain.
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 5) begin
            cycle();
            cyc++;
        end
        check("drain_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
